// File: rtl/seven_seg_pkg.sv
// Shared types and glyph table for the seven-segment display driver.
// Segment vectors are {g,f,e,d,c,b,a}, active-high (1 = segment lit).
package seven_seg_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_OFF    = 7'h00;
  localparam int    MAX_DIGITS = 16;

  // Hex glyphs 0-F: 0 1 2 3 4 5 6 7 8 9 A b C d E F
  localparam seg7_t GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic seg7_t glyph(input logic [3:0] nib);
    return GLYPHS[nib];
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex nibble to seven-segment glyph (active-high segments).
module seg7_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg7_t      seg
);

  assign seg = glyph(nibble);

endmodule

// File: rtl/seven_segment_mux.sv
// Time-multiplexed common-anode seven-segment driver.
// Per-digit decimal point and blanking, leading-zero suppression, PWM
// brightness and frame-synchronous capture of the display inputs.
// Optional: define SEVSEG_GHOST_GUARD_EN to hold all anodes off for the
// first two cycles of every digit dwell (anti-ghosting gap).
module seven_segment_mux
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int COUNT_TO   = 100000,
  parameter int BRIGHT_W   = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [4*NUM_DIGITS-1:0] val_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_suppress_in,
  input  logic [BRIGHT_W-1:0]     brightness_in,
  output logic [6:0]              cat_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_out
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (COUNT_TO > 1) ? $clog2(COUNT_TO) : 1;

  if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("NUM_DIGITS out of range");
  end

  logic [IDX_W-1:0]        idx;
  logic [CNT_W-1:0]        dwell_cnt;
  logic [BRIGHT_W-1:0]     pwm_cnt;
  logic [4*NUM_DIGITS-1:0] sh_val;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic                    sh_lz;

  logic                    dwell_end;
  logic                    frame_wrap;
  logic [NUM_DIGITS-1:0]   dark_vec;
  logic                    seen;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_dark;
  seg7_t                   cur_seg;
  logic                    guard_ok;
  logic                    an_on;

  assign dwell_end  = (dwell_cnt == CNT_W'(COUNT_TO - 1));
  assign frame_wrap = dwell_end && (idx == IDX_W'(NUM_DIGITS - 1));

  // Dwell counter and digit index; each digit is selected for COUNT_TO cycles
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      dwell_cnt <= '0;
      idx       <= '0;
    end else if (dwell_end) begin
      dwell_cnt <= '0;
      idx       <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      dwell_cnt <= dwell_cnt + CNT_W'(1);
    end
  end

  // Free-running PWM phase counter
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + BRIGHT_W'(1);
  end

  // Capture display inputs only as the scan returns to digit 0, so a frame
  // never mixes two input values; frame_out marks the same cycle
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sh_val    <= '0;
      sh_dp     <= '0;
      sh_blank  <= '0;
      sh_lz     <= 1'b0;
      frame_out <= 1'b0;
    end else begin
      frame_out <= frame_wrap;
      if (frame_wrap) begin
        sh_val   <= val_in;
        sh_dp    <= dp_in;
        sh_blank <= blank_in;
        sh_lz    <= lz_suppress_in;
      end
    end
  end

  // Dark digits: blanked, or leading zeros above the first nonzero nibble or
  // lit decimal point, scanning from the leftmost digit; digit 0 always shows
  always_comb begin
    seen     = 1'b0;
    dark_vec = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      seen        = seen | (sh_val[4*k +: 4] != 4'h0) | sh_dp[k];
      dark_vec[k] = sh_blank[k] | (sh_lz & ~seen & (k != 0));
    end
  end

  // Select the shadow fields of the currently scanned digit
  always_comb begin
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    cur_dark = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (IDX_W'(k) == idx) begin
        cur_nib  = sh_val[4*k +: 4];
        cur_dp   = sh_dp[k];
        cur_dark = dark_vec[k];
      end
    end
  end

  seg7_decoder u_dec (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

`ifdef SEVSEG_GHOST_GUARD_EN
  assign guard_ok = (dwell_cnt >= CNT_W'(2));
`else
  assign guard_ok = 1'b1;
`endif

  assign an_on = ~cur_dark && (pwm_cnt <= brightness_in) && guard_ok;

  // Registered pin drivers; all active-low, dark while in reset
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cat_out <= 7'h7F;
      dp_out  <= 1'b1;
      an_out  <= '1;
    end else begin
      cat_out <= cur_dark ? ~SEG_OFF : ~cur_seg;
      dp_out  <= ~(cur_dp & ~cur_dark);
      an_out  <= an_on ? ~(NUM_DIGITS'(1) << idx) : '1;
    end
  end

endmodule
